i_mem_fill: RTL and testbench

Memory-side line-fill engine for the instruction cache. It accepts a line-refill request from the cache (`req`/`address`), reads the line from a pipelined backing store one `TRANS_BITS` word per cycle, and buffers it. It then acknowledges the request and streams the line back to the cache as `BEATS` consecutive beats, one per cycle, starting the cycle after `ack`. It sits between the instruction cache's refill port and instruction memory.

---
 rtl/i_mem_fill_if.sv | 39 +++
 rtl/i_mem_fill.sv | 170 +++++++++++++++++
 tb/tb_i_mem_fill.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/i_mem_fill_if.sv
// Refill-port bundle between the instruction cache, the line-fill engine
// and the backing store. The slave side is the fill engine; the master side
// is the environment (cache request/stream sink plus the memory read port).
interface i_mem_fill_if #(
    parameter int BLOCK_BITS = 64,
    parameter int TRANS_BITS = 16
);
    localparam int BEATS          = BLOCK_BITS / TRANS_BITS;
    localparam int BEAT_BITS      = $clog2(BEATS);
    localparam int LINE_ADDR_BITS = 16 - $clog2(BLOCK_BITS / 8);

    logic                                req;
    logic [LINE_ADDR_BITS-1:0]           address;
    logic                                ack;
    logic [TRANS_BITS-1:0]               data;
    logic                                mem_re;
    logic [LINE_ADDR_BITS+BEAT_BITS-1:0] mem_addr;
    logic [TRANS_BITS-1:0]               mem_rdata;

    modport slave (
        input  req,
        input  address,
        input  mem_rdata,
        output ack,
        output data,
        output mem_re,
        output mem_addr
    );

    modport master (
        output req,
        output address,
        output mem_rdata,
        input  ack,
        input  data,
        input  mem_re,
        input  mem_addr
    );
endinterface

// File: rtl/i_mem_fill.sv
// Instruction-cache line-fill engine: reads a whole line from a pipelined
// backing store into a local buffer, acknowledges the cache, then streams the
// line back one beat per cycle. Every output is a register loaded from the
// next-state values, so nothing on the cache side is combinational from req.
module i_mem_fill #(
    parameter int BLOCK_BITS   = 64,
    parameter int TRANS_BITS   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           n_rst,
    i_mem_fill_if.slave    bus
);
    localparam int BEATS          = BLOCK_BITS / TRANS_BITS;
    localparam int BEAT_BITS      = $clog2(BEATS);
    localparam int LINE_ADDR_BITS = 16 - $clog2(BLOCK_BITS / 8);
    localparam int ADDR_BITS      = LINE_ADDR_BITS + BEAT_BITS;

    localparam logic [BEAT_BITS-1:0] CNT_ONE  = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        ACK    = 3'd3,
        STREAM = 3'd4
    } state_t;

    state_t                    state_reg, state_next;
    logic [LINE_ADDR_BITS-1:0] line_reg, line_next;
    logic [BEAT_BITS-1:0]      issue_cnt_reg, issue_cnt_next;
    logic [BEAT_BITS-1:0]      cap_cnt_reg, cap_cnt_next;
    logic [BEAT_BITS-1:0]      beat_cnt_reg, beat_cnt_next;
    logic                      abort_reg, abort_next;
    logic [READ_LATENCY-1:0]   valid_pipe_reg;

    logic                      ack_reg, ack_next;
    logic                      mem_re_reg, mem_re_next;
    logic [ADDR_BITS-1:0]      mem_addr_reg, mem_addr_next;
    logic [TRANS_BITS-1:0]     data_reg, data_next;

    logic                      capture;
    logic                      req_gone;
    logic [TRANS_BITS-1:0]     line_word [BEATS];

    // The oldest pipe stage lines up with mem_rdata; capture only while a fill
    // is collecting data so nothing stray lands in the buffer.
    assign capture  = valid_pipe_reg[READ_LATENCY-1] &&
                      ((state_reg == ISSUE) || (state_reg == DRAIN));

    // Once the cache lets go of req during the fill, the line is finished
    // internally but never acknowledged or streamed.
    assign req_gone = abort_reg || !bus.req;

    // Line buffer: one word register per beat, written in capture order with
    // beat 0 in the least significant slot. Reset deliberately leaves it alone.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [TRANS_BITS-1:0] word_reg;

            // Load this slot when the capture counter points at it.
            always_ff @(posedge clk) begin
                if (n_rst && capture && (cap_cnt_reg == BEAT_BITS'(gi))) begin
                    word_reg <= bus.mem_rdata;
                end
            end

            assign line_word[gi] = word_reg;
        end
    endgenerate

    // Track outstanding reads: each issued read walks down the pipe and pops
    // out of the tail exactly when its data is on mem_rdata.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_pipe_reg <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
            end
            valid_pipe_reg[0] <= mem_re_reg;
        end
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_next     = state_reg;
        line_next      = line_reg;
        issue_cnt_next = issue_cnt_reg;
        cap_cnt_next   = capture ? (cap_cnt_reg + CNT_ONE) : cap_cnt_reg;
        beat_cnt_next  = beat_cnt_reg;
        abort_next     = abort_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    state_next     = ISSUE;
                    line_next      = bus.address;
                    issue_cnt_next = CNT_ZERO;
                    cap_cnt_next   = CNT_ZERO;
                    abort_next     = 1'b0;
                end
            end
            ISSUE: begin
                issue_cnt_next = issue_cnt_reg + CNT_ONE;
                abort_next     = req_gone;
                if (&issue_cnt_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                abort_next = req_gone;
                if (capture && (&cap_cnt_reg)) begin
                    state_next = req_gone ? IDLE : ACK;
                end
            end
            ACK: begin
                state_next    = STREAM;
                beat_cnt_next = CNT_ZERO;
            end
            STREAM: begin
                beat_cnt_next = beat_cnt_reg + CNT_ONE;
                if (&beat_cnt_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        mem_re_next   = (state_next == ISSUE);
        mem_addr_next = mem_re_next ? {line_next, issue_cnt_next} : '0;
        ack_next      = (state_next == ACK);
        data_next     = (state_next == STREAM) ? line_word[beat_cnt_next] : '0;
    end

    // State, counters and output registers; reset clears everything but the buffer.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            line_reg      <= '0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            beat_cnt_reg  <= '0;
            abort_reg     <= 1'b0;
            ack_reg       <= 1'b0;
            mem_re_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            line_reg      <= line_next;
            issue_cnt_reg <= issue_cnt_next;
            cap_cnt_reg   <= cap_cnt_next;
            beat_cnt_reg  <= beat_cnt_next;
            abort_reg     <= abort_next;
            ack_reg       <= ack_next;
            mem_re_reg    <= mem_re_next;
            mem_addr_reg  <= mem_addr_next;
            data_reg      <= data_next;
        end
    end

    assign bus.ack      = ack_reg;
    assign bus.mem_re   = mem_re_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.data     = data_reg;
endmodule

// File: tb/tb_i_mem_fill.sv
// Directed bench for i_mem_fill: one instance with read latency 1 and one with
// read latency 3, each backed by a pipelined memory whose word w holds A000+w.
module tb_i_mem_fill;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        req;
    logic [12:0] address;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    i_mem_fill_if #(.BLOCK_BITS(64), .TRANS_BITS(16)) bus1 ();
    i_mem_fill_if #(.BLOCK_BITS(64), .TRANS_BITS(16)) bus3 ();

    assign bus1.req     = req;
    assign bus1.address = address;
    assign bus3.req     = req;
    assign bus3.address = address;

    i_mem_fill #(.BLOCK_BITS(64), .TRANS_BITS(16), .READ_LATENCY(1)) dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1)
    );

    i_mem_fill #(.BLOCK_BITS(64), .TRANS_BITS(16), .READ_LATENCY(3)) dut3 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus3)
    );

    // Backing stores: data for the address presented in cycle c appears in c+L.
    logic [15:0] mem1_pipe;
    logic [15:0] mem3_pipe [3];

    always @(posedge clk) begin
        mem1_pipe    <= 16'hA000 + 16'(bus1.mem_addr);
        mem3_pipe[0] <= 16'hA000 + 16'(bus3.mem_addr);
        mem3_pipe[1] <= mem3_pipe[0];
        mem3_pipe[2] <= mem3_pipe[1];
    end

    assign bus1.mem_rdata = mem1_pipe;
    assign bus3.mem_rdata = mem3_pipe[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs in cycle c for a fill whose req was accepted in cycle s:
    // reads in s+1..s+4, ack in s+lat+5, beats in s+lat+6..s+lat+9.
    task automatic chk_fill(input int which, input int c, input int s, input int lat,
                            input logic [15:0] base, input bit has_ack);
        logic        exp_re;
        logic        exp_ack;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        exp_re   = (c >= s + 1) && (c <= s + 4);
        exp_addr = exp_re ? base + 16'(c - s - 1) : 16'h0000;
        exp_ack  = has_ack && (c == s + lat + 5);
        exp_data = (has_ack && (c >= s + lat + 6) && (c <= s + lat + 9)) ?
                   16'hA000 + base + 16'(c - s - lat - 6) : 16'h0000;
        if (which == 1) begin
            chk("d1.ack",      32'(bus1.ack),      32'(exp_ack));
            chk("d1.mem_re",   32'(bus1.mem_re),   32'(exp_re));
            chk("d1.mem_addr", 32'(bus1.mem_addr), 32'(exp_addr));
            chk("d1.data",     32'(bus1.data),     32'(exp_data));
        end else begin
            chk("d3.ack",      32'(bus3.ack),      32'(exp_ack));
            chk("d3.mem_re",   32'(bus3.mem_re),   32'(exp_re));
            chk("d3.mem_addr", 32'(bus3.mem_addr), 32'(exp_addr));
            chk("d3.data",     32'(bus3.data),     32'(exp_data));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst   = 1'b0;
        req     = 1'b0;
        address = '0;
        repeat (3) next_cycle();

        // Reset held: every output at zero.
        @(negedge clk);
        chk_fill(1, 0, -100, 1, 16'h0000, 1'b0);
        chk_fill(3, 0, -100, 3, 16'h0000, 1'b0);
        next_cycle();
        n_rst = 1'b1;

        // Five idle cycles after reset.
        for (int c = 0; c < 5; c++) begin
            cyc = c;
            @(negedge clk);
            chk_fill(1, c, -100, 1, 16'h0000, 1'b0);
            chk_fill(3, c, -100, 3, 16'h0000, 1'b0);
            next_cycle();
        end
        $display("idle after reset: checks=%0d", checks);

        // Basic fill of line 0x0010 on both latencies; address scrambled after acceptance.
        for (int c = 0; c <= 13; c++) begin
            cyc     = c;
            req     = (c <= 7);
            address = (c == 0) ? 13'h0010 : 13'h0555;
            @(negedge clk);
            chk_fill(1, c, 0, 1, 16'h0040, 1'b1);
            chk_fill(3, c, 0, 3, 16'h0040, 1'b1);
            next_cycle();
        end
        $display("basic fill line=0010 lat1/lat3: checks=%0d", checks);

        // Back-to-back: req held, second line 0x1FFF taken in cycle 11.
        for (int c = 0; c <= 22; c++) begin
            cyc     = c;
            req     = (c <= 17);
            address = (c <= 6) ? 13'h0010 : ((c <= 11) ? 13'h1FFF : 13'h0123);
            @(negedge clk);
            if (c <= 10) chk_fill(1, c, 0, 1, 16'h0040, 1'b1);
            else         chk_fill(1, c, 11, 1, 16'h7FFC, 1'b1);
            next_cycle();
        end
        $display("back-to-back fills 0010 then 1FFF: checks=%0d", checks);
        req = 1'b0;
        repeat (10) next_cycle();

        // Abort: req dropped in cycle 3, new fill of line 0x0030 in cycle 6.
        for (int c = 0; c <= 17; c++) begin
            cyc     = c;
            req     = (c <= 2) || ((c >= 6) && (c <= 12));
            address = (c < 6) ? 13'h0020 : 13'h0030;
            @(negedge clk);
            if (c <= 5) chk_fill(1, c, 0, 1, 16'h0080, 1'b0);
            else        chk_fill(1, c, 6, 1, 16'h00C0, 1'b1);
            next_cycle();
        end
        $display("abort of 0020 then fill of 0030: checks=%0d", checks);
        req = 1'b0;
        repeat (10) next_cycle();

        // Reset in cycle 5 of a fill, then a fresh fill of line 0x0050 in cycle 7.
        for (int c = 0; c <= 20; c++) begin
            cyc     = c;
            n_rst   = (c != 5);
            req     = (c <= 4) || ((c >= 7) && (c <= 14));
            address = (c < 7) ? 13'h0040 : 13'h0050;
            @(negedge clk);
            if (c <= 5) begin
                chk_fill(1, c, 0, 1, 16'h0100, 1'b0);
                chk_fill(3, c, 0, 3, 16'h0100, 1'b0);
            end else begin
                chk_fill(1, c, 7, 1, 16'h0140, 1'b1);
                chk_fill(3, c, 7, 3, 16'h0140, 1'b1);
            end
            next_cycle();
        end
        $display("reset mid-fill then fill of 0050: checks=%0d", checks);
        req   = 1'b0;
        n_rst = 1'b1;
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
